pci_target: RTL and testbench

- Parametrised 32-bit PCI target engine that replaces the tristate-only PCI stub. The stub released every bus line; this block actually claims cycles.
- Decodes type-0 configuration cycles and one memory BAR, drives DEVSEL#/TRDY#/STOP#/PAR, and bridges each accepted data phase to a simple local-bus handshake for the back-end logic.
- Sits between the pad-level PCI I/O buffers (the `_I`, `_O` and `OE_*_N` signals) and the application registers.

---
 rtl/pci_pkg.sv | 28 ++
 rtl/pci_if.sv | 31 +++
 rtl/pci_cfg_space.sv | 63 ++++++
 rtl/pci_target.sv | 234 +++++++++++++++++++++++
 tb/tb_pci_target.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - shared PCI command encodings, config offsets and target FSM states
package pci_pkg;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;
    localparam logic [3:0] CMD_CFG_RD = 4'b1010;
    localparam logic [3:0] CMD_CFG_WR = 4'b1011;
    localparam logic [3:0] CMD_MRM    = 4'b1100;
    localparam logic [3:0] CMD_MRL    = 4'b1110;

    localparam logic [5:0] CFG_ID   = 6'h00;
    localparam logic [5:0] CFG_CMD  = 6'h01;
    localparam logic [5:0] CFG_BAR0 = 6'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_XFER,
        ST_BACKOFF,
        ST_TURN
    } state_t;

    function automatic logic is_mem_rd(input logic [3:0] cmd);
        return (cmd == CMD_MEM_RD) || (cmd == CMD_MRM) || (cmd == CMD_MRL);
    endfunction

endpackage

// File: rtl/pci_if.sv
// rtl/pci_if.sv - pad-level PCI target signals with bus-side and target-side views
interface pci_if;
    logic [31:0] AD_I;
    logic [31:0] AD_O;
    logic [3:0]  OE_AD_N;
    logic [3:0]  CBE_I;
    logic        PAR_I;
    logic        PAR_O;
    logic        OE_PAR_N;
    logic        FRAME_I;
    logic        IRDY_I;
    logic        IDSEL_I;
    logic        TRDY_O;
    logic        STOP_O;
    logic        DEVSEL_O;
    logic        OE_TRDY_N;
    logic        OE_STOP_N;
    logic        OE_DEVSEL_N;

    modport slave (
        input  AD_I, CBE_I, PAR_I, FRAME_I, IRDY_I, IDSEL_I,
        output AD_O, OE_AD_N, PAR_O, OE_PAR_N, TRDY_O, STOP_O, DEVSEL_O,
               OE_TRDY_N, OE_STOP_N, OE_DEVSEL_N
    );

    modport master (
        output AD_I, CBE_I, PAR_I, FRAME_I, IRDY_I, IDSEL_I,
        input  AD_O, OE_AD_N, PAR_O, OE_PAR_N, TRDY_O, STOP_O, DEVSEL_O,
               OE_TRDY_N, OE_STOP_N, OE_DEVSEL_N
    );
endinterface

// File: rtl/pci_cfg_space.sv
// rtl/pci_cfg_space.sv - type-0 config header: ID, command and BAR0 registers with read mux
module pci_cfg_space
    import pci_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID = 16'h10EE,
    parameter logic [15:0] DEVICE_ID = 16'h0001,
    parameter int          BAR0_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [5:0]            offset,
    input  logic [31:0]           wdata,
    input  logic [3:0]            be,
    output logic [31:0]           rdata,
    output logic                  mem_en,
    output logic [31-BAR0_LOG2:0] bar0_base
);

    // Low BAR bits are hard-wired to zero so software can size the window.
    localparam logic [31:0] BAR_MASK = ~((32'd1 << BAR0_LOG2) - 32'd1);

    logic [1:0]  cmd_q;
    logic [31:0] bar0_q;
    logic [31:0] bar_wr;

    always_comb begin
        bar_wr = bar0_q;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                bar_wr[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= 2'b00;
            bar0_q <= 32'h0;
        end else if (we) begin
            if (offset == CFG_CMD && be[0]) begin
                cmd_q <= wdata[1:0];
            end
            if (offset == CFG_BAR0) begin
                bar0_q <= bar_wr & BAR_MASK;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (offset)
            CFG_ID:   rdata = {DEVICE_ID, VENDOR_ID};
            CFG_CMD:  rdata = {30'h0, cmd_q};
            CFG_BAR0: rdata = bar0_q;
            default:  rdata = 32'h0;
        endcase
    end

    assign mem_en    = cmd_q[1];
    assign bar0_base = bar0_q[31:BAR0_LOG2];

endmodule

// File: rtl/pci_target.sv
// rtl/pci_target.sv - single-dword PCI target: config + BAR0 decode, bridged to a local bus
module pci_target
    import pci_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID   = 16'h10EE,
    parameter logic [15:0] DEVICE_ID   = 16'h0001,
    parameter int          BAR0_LOG2   = 12,
    parameter int          RETRY_LIMIT = 16
) (
    input  logic                 CLK,
    input  logic                 RST_I,
    pci_if.slave                 pci,
    output logic [BAR0_LOG2-3:0] LB_ADDR,
    output logic [31:0]          LB_WDATA,
    output logic [3:0]           LB_BE,
    output logic                 LB_WR,
    output logic                 LB_RD,
    input  logic [31:0]          LB_RDATA,
    input  logic                 LB_ACK
);

    state_t      state_q, state_d;
    logic        prev_frame_q;
    logic [31:0] addr_q;
    logic [3:0]  cmd_q;
    logic        idsel_q;
    logic        is_cfg_q, is_cfg_d;
    logic        is_rd_q, is_rd_d;
    logic        retry_q, retry_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] ad_q, ad_d;
    logic [3:0]  oe_ad_q, oe_ad_d;
    logic        oe_ctl_q, oe_ctl_d;
    logic        devsel_q, devsel_d;
    logic        trdy_q, trdy_d;
    logic        stop_q, stop_d;
    logic        oe_par_q, par_q;
    logic        lb_rd_q, lb_rd_d;
    logic        lb_wr_q, lb_wr_d;
    logic [31:0] lb_wdata_q;
    logic [3:0]  lb_be_q;
    logic        cfg_we;

    logic                  start, cfg_hit, mem_hit, rd, xfer_done;
    logic [31:0]           cfg_rdata;
    logic                  mem_en;
    logic [31-BAR0_LOG2:0] bar0_base;
    logic                  unused_par;

    pci_cfg_space #(
        .VENDOR_ID (VENDOR_ID),
        .DEVICE_ID (DEVICE_ID),
        .BAR0_LOG2 (BAR0_LOG2)
    ) u_cfg (
        .clk       (CLK),
        .rst_n     (RST_I),
        .we        (cfg_we),
        .offset    (addr_q[7:2]),
        .wdata     (pci.AD_I),
        .be        (~pci.CBE_I),
        .rdata     (cfg_rdata),
        .mem_en    (mem_en),
        .bar0_base (bar0_base)
    );

    assign start     = (state_q == ST_IDLE) && !pci.FRAME_I && prev_frame_q;
    assign cfg_hit   = idsel_q && (cmd_q == CMD_CFG_RD || cmd_q == CMD_CFG_WR) && (addr_q[1:0] == 2'b00);
    assign mem_hit   = mem_en && (is_mem_rd(cmd_q) || cmd_q == CMD_MEM_WR)
                       && (addr_q[31:BAR0_LOG2] == bar0_base);
    assign rd        = cfg_hit ? (cmd_q == CMD_CFG_RD) : is_mem_rd(cmd_q);
    assign xfer_done = !trdy_q && !pci.IRDY_I;

    always_comb begin
        state_d  = state_q;
        is_cfg_d = is_cfg_q;
        is_rd_d  = is_rd_q;
        retry_d  = retry_q;
        cnt_d    = cnt_q;
        ad_d     = ad_q;
        oe_ad_d  = oe_ad_q;
        oe_ctl_d = oe_ctl_q;
        devsel_d = devsel_q;
        trdy_d   = trdy_q;
        stop_d   = stop_q;
        lb_rd_d  = 1'b0;
        lb_wr_d  = 1'b0;
        cfg_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DECODE;
                    cnt_d   = 16'd0;
                    retry_d = 1'b0;
                end
            end
            ST_DECODE: begin
                cnt_d = cnt_q + 16'd1;
                if (cfg_hit || mem_hit) begin
                    devsel_d = 1'b0;
                    oe_ctl_d = 1'b0;
                    is_cfg_d = cfg_hit;
                    is_rd_d  = rd;
                    oe_ad_d  = rd ? 4'h0 : 4'hF;
                    ad_d     = 32'h0;
                    if (cfg_hit) begin
                        state_d = ST_WAIT;
                    end else if (rd) begin
                        lb_rd_d = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        trdy_d  = 1'b0;
                        stop_d  = pci.FRAME_I;
                        state_d = ST_XFER;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A completion in the same clock as the retry deadline wins.
                if (is_cfg_q || LB_ACK) begin
                    if (is_rd_q) begin
                        ad_d = is_cfg_q ? cfg_rdata : LB_RDATA;
                    end
                    trdy_d  = 1'b0;
                    stop_d  = pci.FRAME_I;
                    state_d = ST_XFER;
                end else if (cnt_q == 16'(RETRY_LIMIT - 1)) begin
                    stop_d  = 1'b0;
                    retry_d = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (retry_q ? pci.FRAME_I : xfer_done) begin
                    if (!retry_q && !is_rd_q) begin
                        cfg_we  = is_cfg_q;
                        lb_wr_d = !is_cfg_q;
                    end
                    devsel_d = 1'b1;
                    trdy_d   = 1'b1;
                    stop_d   = 1'b1;
                    oe_ad_d  = 4'hF;
                    state_d  = ST_BACKOFF;
                end else if (!retry_q) begin
                    stop_d = pci.FRAME_I;
                end
            end
            ST_BACKOFF: begin
                oe_ctl_d = 1'b1;
                state_d  = ST_TURN;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_I) begin
        if (!RST_I) begin
            state_q      <= ST_IDLE;
            prev_frame_q <= 1'b1;
            addr_q       <= 32'h0;
            cmd_q        <= 4'h0;
            idsel_q      <= 1'b0;
            is_cfg_q     <= 1'b0;
            is_rd_q      <= 1'b0;
            retry_q      <= 1'b0;
            cnt_q        <= 16'd0;
            ad_q         <= 32'h0;
            oe_ad_q      <= 4'hF;
            oe_ctl_q     <= 1'b1;
            devsel_q     <= 1'b1;
            trdy_q       <= 1'b1;
            stop_q       <= 1'b1;
            oe_par_q     <= 1'b1;
            par_q        <= 1'b0;
            lb_rd_q      <= 1'b0;
            lb_wr_q      <= 1'b0;
            lb_wdata_q   <= 32'h0;
            lb_be_q      <= 4'h0;
        end else begin
            state_q      <= state_d;
            prev_frame_q <= pci.FRAME_I;
            is_cfg_q     <= is_cfg_d;
            is_rd_q      <= is_rd_d;
            retry_q      <= retry_d;
            cnt_q        <= cnt_d;
            ad_q         <= ad_d;
            oe_ad_q      <= oe_ad_d;
            oe_ctl_q     <= oe_ctl_d;
            devsel_q     <= devsel_d;
            trdy_q       <= trdy_d;
            stop_q       <= stop_d;
            par_q        <= ^ad_q ^ ^pci.CBE_I;
            oe_par_q     <= oe_ad_q[0];
            lb_rd_q      <= lb_rd_d;
            lb_wr_q      <= lb_wr_d;
            if (start) begin
                addr_q  <= pci.AD_I;
                cmd_q   <= pci.CBE_I;
                idsel_q <= pci.IDSEL_I;
            end
            if (lb_wr_d) begin
                lb_wdata_q <= pci.AD_I;
                lb_be_q    <= ~pci.CBE_I;
            end
        end
    end

    assign pci.AD_O        = ad_q;
    assign pci.OE_AD_N     = oe_ad_q;
    assign pci.PAR_O       = par_q;
    assign pci.OE_PAR_N    = oe_par_q;
    assign pci.DEVSEL_O    = devsel_q;
    assign pci.TRDY_O      = trdy_q;
    assign pci.STOP_O      = stop_q;
    assign pci.OE_DEVSEL_N = oe_ctl_q;
    assign pci.OE_TRDY_N   = oe_ctl_q;
    assign pci.OE_STOP_N   = oe_ctl_q;

    assign LB_ADDR  = addr_q[BAR0_LOG2-1:2];
    assign LB_WDATA = lb_wdata_q;
    assign LB_BE    = lb_be_q;
    assign LB_WR    = lb_wr_q;
    assign LB_RD    = lb_rd_q;

    assign unused_par = pci.PAR_I;

endmodule

// File: tb/tb_pci_target.sv
// tb/tb_pci_target.sv - directed self-checking bench for pci_target
module tb_pci_target;
    import pci_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_I = 1'b0;
    logic [9:0]  lb_addr;
    logic [31:0] lb_wdata;
    logic [3:0]  lb_be;
    logic        lb_wr, lb_rd;
    logic [31:0] lb_rdata;
    logic        lb_ack;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    pci_if bus();

    pci_target dut (
        .CLK      (CLK),
        .RST_I    (RST_I),
        .pci      (bus),
        .LB_ADDR  (lb_addr),
        .LB_WDATA (lb_wdata),
        .LB_BE    (lb_be),
        .LB_WR    (lb_wr),
        .LB_RD    (lb_rd),
        .LB_RDATA (lb_rdata),
        .LB_ACK   (lb_ack)
    );

    initial forever #5 CLK = ~CLK;

    logic [7:0] oe_all;
    logic [2:0] ctl;
    assign oe_all = {bus.OE_AD_N, bus.OE_PAR_N, bus.OE_TRDY_N, bus.OE_STOP_N, bus.OE_DEVSEL_N};
    assign ctl    = {bus.DEVSEL_O, bus.TRDY_O, bus.STOP_O};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_bus;
        bus.FRAME_I = 1'b1;
        bus.IRDY_I  = 1'b1;
        bus.IDSEL_I = 1'b0;
        bus.AD_I    = 32'h0;
        bus.CBE_I   = 4'hF;
        lb_ack      = 1'b0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] c, input logic sel);
        bus.FRAME_I = 1'b0;
        bus.AD_I    = a;
        bus.CBE_I   = c;
        bus.IDSEL_I = sel;
        tick;
        bus.IDSEL_I = 1'b0;
    endtask

    task automatic cfg_wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] cbe);
        addr_phase({24'h0, off}, CMD_CFG_WR, 1'b1);
        bus.FRAME_I = 1'b1;
        bus.IRDY_I  = 1'b0;
        bus.AD_I    = data;
        bus.CBE_I   = cbe;
        tick;
        tick;
        tick;
        idle_bus();
        tick;
        tick;
    endtask

    task automatic cfg_rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
        addr_phase({24'h0, off}, CMD_CFG_RD, 1'b1);
        bus.FRAME_I = 1'b1;
        bus.IRDY_I  = 1'b0;
        bus.AD_I    = 32'h0;
        bus.CBE_I   = 4'h0;
        tick;
        tick;
        chk(tag, bus.AD_O, exp);
        tick;
        idle_bus();
        tick;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bus.PAR_I = 1'b0;
        lb_rdata  = 32'h0;
        idle_bus();
        tick;
        tick;
        chk("rst_oe", {24'h0, oe_all}, 32'hFF);
        chk("rst_ctl", {29'h0, ctl}, 32'h7);
        chk("rst_ad_par", {bus.AD_O[30:0], bus.PAR_O}, 32'h0);
        chk("rst_lb", {30'h0, lb_wr, lb_rd}, 32'h0);
        RST_I = 1'b1;
        tick;

        // config read of the ID dword, cycle by cycle
        addr_phase(32'h0, CMD_CFG_RD, 1'b1);
        bus.FRAME_I = 1'b1;
        bus.IRDY_I  = 1'b0;
        bus.AD_I    = 32'h0;
        bus.CBE_I   = 4'h0;
        tick;
        chk("id_a1_ctl", {29'h0, ctl}, 32'h3);
        chk("id_a1_oe", {24'h0, oe_all}, 32'h08);
        tick;
        chk("id_a2_ctl", {29'h0, ctl}, 32'h1);
        chk("id_a2_ad", bus.AD_O, 32'h0001_10EE);
        tick;
        chk("id_a3_ctl", {29'h0, ctl}, 32'h7);
        chk("id_a3_oe", {24'h0, oe_all}, 32'hF0);
        chk("id_a3_par", {31'h0, bus.PAR_O}, 32'h0);
        idle_bus();
        tick;
        chk("id_turn_oe", {24'h0, oe_all}, 32'hFF);
        tick;

        cfg_rd(8'h04, 32'h0, "cmd_reset");
        cfg_rd(8'h08, 32'h0, "unimpl_off");
        cfg_wr(8'h10, 32'hFFFF_FFFF, 4'h0);
        cfg_rd(8'h10, 32'hFFFF_F000, "bar_size");
        cfg_wr(8'h10, 32'h0000_0000, 4'b1000);
        cfg_rd(8'h10, 32'hFF00_0000, "bar_be");
        cfg_wr(8'h10, 32'h8000_0000, 4'h0);
        cfg_rd(8'h10, 32'h8000_0000, "bar_set");
        cfg_wr(8'h04, 32'h0000_0003, 4'b0001);
        cfg_rd(8'h04, 32'h0, "cmd_be_off");
        cfg_wr(8'h04, 32'hFFFF_FFFE, 4'h0);
        cfg_rd(8'h04, 32'h2, "cmd_mask");

        // memory write with FRAME held: disconnect with data
        addr_phase(32'h8000_0010, CMD_MEM_WR, 1'b0);
        bus.IRDY_I = 1'b0;
        bus.AD_I   = 32'hDEAD_BEEF;
        bus.CBE_I  = 4'h0;
        tick;
        chk("mw_a1_ctl", {29'h0, ctl}, 32'h0);
        chk("mw_a1_oe", {24'h0, oe_all}, 32'hF8);
        chk("mw_a1_wr", {31'h0, lb_wr}, 32'h0);
        tick;
        chk("mw_wr", {31'h0, lb_wr}, 32'h1);
        chk("mw_data", lb_wdata, 32'hDEAD_BEEF);
        chk("mw_addr_be", {18'h0, lb_addr, lb_be}, {18'h0, 10'd4, 4'hF});
        idle_bus();
        tick;
        chk("mw_pulse", {31'h0, lb_wr}, 32'h0);
        tick;

        // memory read, ack three clocks after LB_RD
        addr_phase(32'h8000_0020, CMD_MEM_RD, 1'b0);
        bus.FRAME_I = 1'b1;
        bus.IRDY_I  = 1'b0;
        bus.AD_I    = 32'h0;
        bus.CBE_I   = 4'h0;
        tick;
        chk("mr_rd", {31'h0, lb_rd}, 32'h1);
        chk("mr_a1_ctl_oe", {21'h0, ctl, oe_all}, {21'h0, 3'h3, 8'h08});
        chk("mr_addr", {22'h0, lb_addr}, 32'd8);
        tick;
        chk("mr_rd_pulse", {31'h0, lb_rd}, 32'h0);
        tick;
        chk("mr_a3_ctl", {29'h0, ctl}, 32'h3);
        lb_ack   = 1'b1;
        lb_rdata = 32'h1234_5678;
        tick;
        lb_ack = 1'b0;
        chk("mr_data", bus.AD_O, 32'h1234_5678);
        chk("mr_a4_ctl", {29'h0, ctl}, 32'h1);
        tick;
        chk("mr_backoff", {21'h0, ctl, oe_all}, {21'h0, 3'h7, 8'hF0});
        chk("mr_par", {31'h0, bus.PAR_O}, 32'h1);
        idle_bus();
        tick;
        chk("mr_turn_oe", {24'h0, oe_all}, 32'hFF);
        tick;

        // read with no ack: retry at A+16, late ack discarded
        addr_phase(32'h8000_0030, CMD_MEM_RD, 1'b0);
        bus.IRDY_I = 1'b0;
        bus.AD_I   = 32'h0;
        bus.CBE_I  = 4'h0;
        for (int i = 0; i < 15; i++) tick;
        chk("rt_a15_ctl", {29'h0, ctl}, 32'h3);
        tick;
        chk("rt_a16_ctl", {29'h0, ctl}, 32'h2);
        lb_ack   = 1'b1;
        lb_rdata = 32'hAAAA_5555;
        tick;
        lb_ack = 1'b0;
        chk("rt_hold", {29'h0, ctl}, 32'h2);
        chk("rt_ad", bus.AD_O, 32'h0);
        bus.FRAME_I = 1'b1;
        tick;
        chk("rt_backoff", {21'h0, ctl, oe_all}, {21'h0, 3'h7, 8'hF0});
        idle_bus();
        tick;
        chk("rt_turn_oe", {24'h0, oe_all}, 32'hFF);
        tick;

        // ack in the same clock as the retry deadline completes the read
        addr_phase(32'h8000_0034, CMD_MRL, 1'b0);
        bus.FRAME_I = 1'b1;
        bus.IRDY_I  = 1'b0;
        bus.AD_I    = 32'h0;
        bus.CBE_I   = 4'h0;
        for (int i = 0; i < 15; i++) tick;
        lb_ack   = 1'b1;
        lb_rdata = 32'hCAFE_F00D;
        tick;
        lb_ack = 1'b0;
        chk("ae_ctl", {29'h0, ctl}, 32'h1);
        chk("ae_data", bus.AD_O, 32'hCAFE_F00D);
        tick;
        idle_bus();
        tick;
        tick;

        // address outside BAR0
        addr_phase(32'h4000_0000, CMD_MEM_RD, 1'b0);
        bus.FRAME_I = 1'b1;
        bus.IRDY_I  = 1'b0;
        tick;
        chk("miss_a1", {21'h0, ctl, oe_all}, {21'h0, 3'h7, 8'hFF});
        tick;
        chk("miss_a2", {23'h0, lb_rd, oe_all}, {23'h0, 1'b0, 8'hFF});
        idle_bus();
        tick;

        // memory space disabled
        cfg_wr(8'h04, 32'h0, 4'h0);
        addr_phase(32'h8000_0000, CMD_MEM_RD, 1'b0);
        bus.FRAME_I = 1'b1;
        bus.IRDY_I  = 1'b0;
        tick;
        chk("memdis_a1", {20'h0, lb_rd, ctl, oe_all}, {20'h0, 1'b0, 3'h7, 8'hFF});
        idle_bus();
        tick;
        tick;
        cfg_wr(8'h04, 32'h2, 4'h0);

        // asynchronous reset while the target owns the bus
        addr_phase(32'h8000_0040, CMD_MEM_WR, 1'b0);
        bus.IRDY_I = 1'b1;
        bus.AD_I   = 32'h1111_1111;
        bus.CBE_I  = 4'h0;
        tick;
        chk("rx_driving", {24'h0, oe_all}, 32'hF8);
        #2;
        RST_I = 1'b0;
        #1;
        chk("rx_oe", {24'h0, oe_all}, 32'hFF);
        chk("rx_ctl", {28'h0, lb_wr, ctl}, 32'h7);
        #1;
        RST_I = 1'b1;
        idle_bus();
        tick;
        tick;
        cfg_rd(8'h04, 32'h0, "rx_cmd_clr");
        cfg_rd(8'h10, 32'h0, "rx_bar_clr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
